// File: rtl/data_bus_arbiter.sv
// Two-master, single-slave data bus arbiter with m1 bus locking and a one-cycle registered read return.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; otherwise m0 has fixed priority.
module data_bus_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [3:0]        m0_width,
  input  logic              m1_req,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [3:0]        m1_width,
  input  logic              m1_lock,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] bus_address,
  output logic [DATA_W-1:0] bus_data_out,
  output logic [3:0]        bus_width,
  output logic              bus_write,
  input  logic [DATA_W-1:0] rom_rdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);

  typedef enum logic [1:0] {GNT_NONE, GNT_M0, GNT_M1} gnt_e;

  gnt_e       gnt_sel;
  logic       locked;
  logic [7:0] lock_cnt;
  logic       rvalid_q;
  logic       rsel_q;
  logic       rown_q;
  logic       normal_m1;

`ifdef ARB_ROUND_ROBIN_EN
  logic owner_last;
  // rr_fresh gives m0 the first contended beat after reset, since owner_last resets to 0.
  logic rr_fresh;

  always_comb normal_m1 = !rr_fresh && !owner_last;
`else
  always_comb normal_m1 = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gnt_sel = GNT_NONE;
    if (locked && m1_req && (lock_cnt < LOCK_MAX))
      gnt_sel = GNT_M1;
    else if (locked && (lock_cnt == LOCK_MAX) && m0_req)
      gnt_sel = GNT_M0;
    else if (m0_req && m1_req)
      gnt_sel = normal_m1 ? GNT_M1 : GNT_M0;
    else if (m0_req)
      gnt_sel = GNT_M0;
    else if (m1_req)
      gnt_sel = GNT_M1;
  end

  assign m0_gnt = (gnt_sel == GNT_M0);
  assign m1_gnt = (gnt_sel == GNT_M1);

  always_comb begin
    bus_write    = 1'b0;
    bus_address  = '0;
    bus_data_out = '0;
    bus_width    = '0;
    case (gnt_sel)
      GNT_M0: begin
        bus_write    = m0_write;
        bus_address  = m0_addr;
        bus_data_out = m0_wdata;
        bus_width    = m0_width;
      end
      GNT_M1: begin
        bus_write    = m1_write;
        bus_address  = m1_addr;
        bus_data_out = m1_wdata;
        bus_width    = m1_width;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rsel_q   <= 1'b0;
      rown_q   <= 1'b0;
      locked   <= 1'b0;
      lock_cnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      owner_last <= 1'b0;
      rr_fresh   <= 1'b1;
`endif
    end else begin
      rvalid_q <= (gnt_sel != GNT_NONE) && !bus_write;
      if (gnt_sel != GNT_NONE) begin
        rsel_q <= bus_address[ADDR_W-1];
        rown_q <= (gnt_sel == GNT_M1);
      end

      if (gnt_sel == GNT_M0) begin
        locked   <= 1'b0;
        lock_cnt <= '0;
      end else if (gnt_sel == GNT_M1) begin
        if (m1_lock) begin
          locked <= 1'b1;
          if (lock_cnt < LOCK_MAX) lock_cnt <= lock_cnt + 8'd1;
        end else begin
          locked   <= 1'b0;
          lock_cnt <= '0;
        end
      end else if (locked && !m1_req) begin
        locked   <= 1'b0;
        lock_cnt <= '0;
      end

`ifdef ARB_ROUND_ROBIN_EN
      if (gnt_sel != GNT_NONE) begin
        owner_last <= (gnt_sel == GNT_M1);
        rr_fresh   <= 1'b0;
      end
`endif
    end
  end

  always_comb begin
    m0_rvalid = rvalid_q && !rown_q;
    m1_rvalid = rvalid_q && rown_q;
    m0_rdata  = '0;
    m1_rdata  = '0;
    if (m0_rvalid) m0_rdata = rsel_q ? ram_rdata : rom_rdata;
    if (m1_rvalid) m1_rdata = rsel_q ? ram_rdata : rom_rdata;
  end

endmodule
